// File: rtl/uart_rx.sv
// uart_rx: Wishbone dbus UART receiver; decodes serial rx into a byte FIFO, irq while non-empty.
// Build option: define UART_RX_PARITY_EN for 8E1 framing with parity check (STATUS[4] = PERR).
module uart_rx #(
    parameter int unsigned       AWIDTH     = 8,
    parameter logic [AWIDTH-1:0] ADDR       = 8'h60,
    parameter int unsigned       DIVIDE     = 278,
    parameter int unsigned       DEPTH_LOG2 = 4
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic [31:0] wb_dbus_adr,
    input  logic [31:0] wb_dbus_dat,
    input  logic [3:0]  wb_dbus_sel,
    input  logic        wb_dbus_we,
    input  logic        wb_dbus_cyc,
    output logic [31:0] rdt,
    output logic        ack,
    input  logic        rx,
    output logic        irq
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = $clog2(DIVIDE + 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(DIVIDE / 2);
    // Sampling at count 0 after a reload of DIVIDE-1 gives exactly DIVIDE cycles per bit.
    localparam logic [CW-1:0] BIT_CNT  = CW'(DIVIDE - 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic rx_meta, rx_sync, rx_prev, rx_fall;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_req, ferr_set;
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            perr_set, perr_q;
`endif

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  empty, full, push, pop, ovr_set;
    logic                  ovr_q, ferr_q;

    logic        sel, clr;
    logic [31:0] reg_val;
    logic        unused_bus;

    assign unused_bus = &{1'b0, wb_dbus_sel, wb_dbus_dat, wb_dbus_adr};

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_set  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_fall) begin
                    cnt_d   = HALF_CNT;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (!rx_sync) begin
                        cnt_d   = BIT_CNT;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = rx_sync;
                    cnt_d          = BIT_CNT;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == '0) begin
                    par_bad_d = ^{shift_q, rx_sync};
                    perr_set  = ^{shift_q, rx_sync};
                    cnt_d     = BIT_CNT;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (rx_sync) begin
`ifdef UART_RX_PARITY_EN
                        push_req = ~par_bad_q;
`else
                        push_req = 1'b1;
`endif
                        state_d  = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (rx_sync) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop     = ack & ~wb_dbus_we & ~wb_dbus_adr[2] & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push    = push_req & (~full | pop);
    assign ovr_set = push_req & full & ~pop;

    always_ff @(posedge wb_clk) begin
        if (push) mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign sel = wb_dbus_cyc & (wb_dbus_adr[31 -: AWIDTH] == ADDR);
    assign clr = ack & wb_dbus_we & wb_dbus_adr[2];

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ack    <= 1'b0;
            irq    <= 1'b0;
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else begin
            ack <= sel & ~ack;
            irq <= ~empty;
            if (ovr_set)                   ovr_q  <= 1'b1;
            else if (clr & wb_dbus_dat[2]) ovr_q  <= 1'b0;
            if (ferr_set)                  ferr_q <= 1'b1;
            else if (clr & wb_dbus_dat[3]) ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (perr_set)                  perr_q <= 1'b1;
            else if (clr & wb_dbus_dat[4]) perr_q <= 1'b0;
`endif
        end
    end

    always_comb begin
        reg_val = '0;
        if (wb_dbus_adr[2]) begin
            reg_val[0] = ~empty;
            reg_val[1] = full;
            reg_val[2] = ovr_q;
            reg_val[3] = ferr_q;
`ifdef UART_RX_PARITY_EN
            reg_val[4] = perr_q;
`endif
            reg_val[8 +: DEPTH_LOG2+1] = count_q;
        end else if (!empty) begin
            reg_val[7:0] = mem[rd_ptr_q];
        end
        rdt = ack ? reg_val : '0;
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx; bus reads queue expectations, a monitor checks acks.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int DIV   = 8;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;
    localparam logic [31:0] BASE  = 32'h6000_0000;
    localparam logic [31:0] OTHER = 32'h7000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr, dat, rdt;
    logic [3:0]  sel;
    logic        we, cyc, ack, rx, irq;

    always #5 clk = ~clk;

    uart_rx #(.AWIDTH(8), .ADDR(8'h60), .DIVIDE(DIV), .DEPTH_LOG2(DL2)) dut (
        .wb_clk(clk), .wb_rst_n(rst_n), .wb_dbus_adr(adr), .wb_dbus_dat(dat),
        .wb_dbus_sel(sel), .wb_dbus_we(we), .wb_dbus_cyc(cyc),
        .rdt(rdt), .ack(ack), .rx(rx), .irq(irq)
    );

    typedef struct {
        bit          chk;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    byte unsigned model_q[$];
    bit          m_ovr, m_ferr, m_perr;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = model_q.size() != 0;
        s[1]    = model_q.size() == DEPTH;
        s[2]    = m_ovr;
        s[3]    = m_ferr;
        s[4]    = m_perr;
        s[15:8] = 8'(model_q.size());
        return s;
    endfunction

    // Monitor: every ack pops one expectation; outside acks rdt must be zero.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ack) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack: got ack=1 rdt=%h, expected no ack", rdt);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.chk) check(e.name, rdt, e.val);
                end
            end else begin
                check("rdt_idle", rdt, 32'h0);
            end
        end
    end

    task automatic bus(input logic [31:0] a, input bit w, input logic [31:0] d,
                       input bit chk, input logic [31:0] exp, input string name);
        int n;
        sb.push_back('{chk, exp, name});
        @(posedge clk); #1;
        cyc = 1'b1; adr = a; we = w; dat = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        check({name, "_ack_latency"}, n, 2);
        @(posedge clk); #1;
        cyc = 1'b0; we = 1'b0;
    endtask

    task automatic rd_data(input string name);
        logic [31:0] e;
        e = '0;
        if (model_q.size() != 0) e[7:0] = model_q.pop_front();
        bus(BASE, 1'b0, '0, 1'b1, e, name);
    endtask

    task automatic rd_status(input string name);
        bus(BASE | 32'h4, 1'b0, '0, 1'b1, model_status(), name);
    endtask

    task automatic wr_status(input logic [31:0] v);
        bus(BASE | 32'h4, 1'b1, v, 1'b0, '0, "wr_status");
        if (v[2]) m_ovr  = 1'b0;
        if (v[3]) m_ferr = 1'b0;
        if (v[4]) m_perr = 1'b0;
    endtask

    task automatic drive_bit(input bit v);
        rx = v;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    // Sends one frame; stop_low>0 holds the stop bit low that many bit times.
    task automatic send_frame(input byte unsigned b, input int stop_low, input bit par_good);
        bit par_ok;
        par_ok = 1'b1;
        @(posedge clk); #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_good ? ^b : ~^b);
        par_ok = par_good;
`endif
        if (stop_low == 0) drive_bit(1'b1);
        else repeat (stop_low) drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        if (!par_ok) m_perr = 1'b1;
        if (stop_low != 0) m_ferr = 1'b1;
        else if (par_ok) begin
            if (model_q.size() == DEPTH) m_ovr = 1'b1;
            else model_q.push_back(b);
        end
        check("irq_after_frame", irq, model_q.size() != 0);
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ack;
        rx = 1'b1; cyc = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = 4'hF;
        m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdt", rdt, 32'h0);
        check("reset_ack", ack, 32'h0);
        check("reset_irq", irq, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        rd_status("status_reset");

        send_frame(8'hA5, 0, 1'b1);
        rd_status("status_a5");
        rd_data("data_a5");
        rd_status("status_after_a5");
        @(negedge clk);
        check("irq_cleared", irq, 32'h0);

        for (int i = 0; i <= 16; i++) send_frame(8'(i), 0, 1'b1);
        rd_status("status_overflow");
        for (int i = 0; i < 16; i++) rd_data("data_fifo_order");
        rd_status("status_drained");
        wr_status(32'h4);
        rd_status("status_ovr_cleared");

        send_frame(8'h3C, 3, 1'b1);
        rd_status("status_ferr");
        wr_status(32'h8);
        rd_status("status_ferr_cleared");

        @(posedge clk); #1;
        rx = 1'b0;
        repeat (DIV / 4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3 * DIV) @(posedge clk);
        rd_status("status_glitch");
        send_frame(8'h55, 0, 1'b1);
        rd_data("data_55");

        rd_data("data_empty");
        rd_status("status_empty");
        @(posedge clk); #1;
        cyc = 1'b1; adr = OTHER; we = 1'b0;
        n_ack = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        check("unselected_ack_count", n_ack, 0);
        @(posedge clk); #1;
        cyc = 1'b0;

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 0, 1'b1);
        rd_data("data_parity_good");
        send_frame(8'h07, 0, 1'b0);
        rd_status("status_perr");
        wr_status(32'h10);
        rd_status("status_perr_cleared");
`endif

        @(posedge clk); #1;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rst_n = 1'b0;
        rx = 1'b1;
        model_q.delete();
        m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
        #1;
        check("midframe_reset_ack", ack, 32'h0);
        check("midframe_reset_irq", irq, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8 * DIV) @(posedge clk);
        rd_status("status_after_midframe_reset");

        repeat (24) begin
            int kind, op;
            byte unsigned b;
            b    = 8'($urandom);
            kind = $urandom_range(0, 9);
            if (kind == 0)      send_frame(b, $urandom_range(1, 3), 1'b1);
            else if (kind == 1) send_frame(b, 0, 1'b0);
            else                send_frame(b, 0, 1'b1);
            op = $urandom_range(0, 3);
            if (op == 1) rd_data("rand_data");
            else if (op == 2) rd_status("rand_status");
            else if (op == 3) wr_status(32'($urandom_range(0, 7)) << 2);
        end
        rd_status("rand_status_final");
        while (model_q.size() != 0) rd_data("drain_data");
        rd_data("drain_empty");
        wr_status(32'h1C);
        rd_status("status_end");

        repeat (4) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Wishbone dbus UART receiver; the receive-side counterpart of the existing `uart` transmitter.
- Decodes 8N1 serial from an `rx` pin into a byte FIFO.
- CPU reads bytes and status over the SERV dbus.
- `irq` feeds one `irq_reg` input, so firmware can service input without polling.

Parameters:
- ADDR, 8'h60, dbus device address compared against wb_dbus_adr[31:32-AWIDTH]
- AWIDTH, 8, number of upper address bits decoded
- DIVIDE, 278, wb_clk cycles per bit (278 = 115200 baud at 32 MHz)
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 bytes

Ports:
- wb_clk  in  1  system clock
- wb_rst_n  in  1  asynchronous active-low reset
- wb_dbus_adr  in  32  dbus address
- wb_dbus_dat  in  32  dbus write data
- wb_dbus_sel  in  4  byte selects (ignored; full-word access)
- wb_dbus_we  in  1  write enable
- wb_dbus_cyc  in  1  bus cycle
- rdt  out  32  read data; 0 when not acking (OR-bus rule)
- ack  out  1  single-cycle acknowledge
- rx  in  1  async serial input, idle high
- irq  out  1  high while FIFO non-empty

Behaviour:
- Reset (async, wb_rst_n=0):
  - rdt=0, ack=0, irq=0.
  - FIFO empty; error flags clear; FSM IDLE.
  - Synchronizer flops preset to 1.
- rx passes through a 2-flop synchronizer; all decode uses the synchronized value.
- FSM states:
  - IDLE: on a synchronized falling edge, load bit counter with DIVIDE/2, go to START.
  - START: at count 0, sample rx. If 0, go to DATA with count DIVIDE and bit index 0. If 1 (glitch), return to IDLE with no flag.
  - DATA: every DIVIDE cycles, sample rx into shift[idx] (LSB first). After idx 7, go to STOP.
  - STOP: after DIVIDE cycles, sample rx.
    - rx=1: push byte, go to IDLE.
    - rx=0: set FERR, discard byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx=1, then go to IDLE. This prevents a break condition from generating bytes.
- FIFO push rules:
  - Push happens in the same cycle as the stop sample.
  - If full, the byte is dropped, OVR is set, and FIFO contents are unchanged.
- Bus decode: selected when wb_dbus_cyc=1 and the address field == ADDR. Register index = wb_dbus_adr[2].
  - 0 DATA (read): {24'b0, head byte}. The pop occurs on the ack cycle. Reading while empty returns 0 with no pop and no underflow.
  - 1 STATUS (read): [0]=not empty, [1]=full, [2]=OVR, [3]=FERR, [4]=PERR, [15:8]=fill count.
  - 1 STATUS (write): bits [4:2] written as 1 clear the matching flags (W1C).
  - Writes to DATA are acked and ignored.
- Ack timing:
  - ack=1 exactly one cycle after a selected cyc is first seen.
  - ack is forced low in the cycle after an ack, so back-to-back accesses each get one pulse.
  - rdt is valid only while ack=1; otherwise 0.
- Simultaneous push and pop:
  - Both occur; the count is unchanged.
  - When full, the pop frees a slot for the simultaneous push, so no overflow.
- A flag W1C in the same cycle as a new error: the set wins.
- Fill count width is DEPTH_LOG2+1 bits, zero-extended into [15:8]. Pointers wrap modulo DEPTH.
- irq = not empty, registered; it goes high one cycle after the push.
- Reset mid-frame aborts the frame; the partial byte is never pushed.

Optional Feature:
- Macro name: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; a PARITY state follows DATA and samples one extra bit.
  - If the parity bit breaks even parity, PERR is set and the byte is discarded; the stop check still runs.
- Undefined:
  - Frame is 8N1; no PARITY state.
  - STATUS[4] always reads 0.

Test Plan:
- DIVIDE=8, send 0xA5 8N1 on rx -> irq rises; STATUS reads 0x0000_0101; DATA reads 0x0000_00A5; then STATUS=0, irq=0.
- Send 17 bytes 0x00..0x10 with DEPTH_LOG2=4, no reads -> STATUS [1]=1, [2]=1, count=16; reads return 0x00..0x0F in order; 0x10 lost.
- Send 0x3C with the stop bit held 0 for 3 bit times, then idle -> FERR=1, FIFO empty; writing STATUS=0x8 clears FERR.
- Pulse rx low for DIVIDE/4 cycles -> no byte and no flags; a following 0x55 frame is received correctly.
- Read DATA when empty -> ack in 1 cycle, rdt=0, count stays 0; a non-selected address -> ack=0, rdt=0.
- With UART_RX_PARITY_EN: 0x07 with parity 1 -> accepted; 0x07 with parity 0 -> PERR=1, FIFO empty.
